// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with variable-latency imem, redirect kill and stall hold
//
// Purpose:
//   Owns the fetch PC, keeps at most one instruction-memory read in flight,
//   presents PC/instruction to the IF/ID register, inserts NOP bubbles while
//   memory is slow, discards fetches killed by an EX redirect and buffers a
//   returned instruction while the hazard unit stalls fetch.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          asynchronous reset, active-high
//   i_stall_f      hazard unit: hold current fetch output
//   i_pcsrc_e      redirect request from EX (taken branch/jump)
//   i_pctarget_e   redirect target, bits [1:0] ignored
//   o_imem_req     single-cycle read request pulse
//   o_imem_addr    read address, meaningful only while o_imem_req=1
//   i_imem_rvalid  read data valid, one pulse per request
//   i_imem_rdata   instruction word, valid with i_imem_rvalid
//   o_pc_f         PC of the instruction on o_instr_f
//   o_instr_f      instruction to IF/ID, NOP_INSTR when o_valid_f=0
//   o_valid_f      o_instr_f is a real fetched instruction
//   o_bubble_cnt   saturating count of cycles with o_valid_f=0 and i_stall_f=0

module fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall_f,
    input  logic             i_pcsrc_e,
    input  logic [63:0]      i_pctarget_e,
    output logic             o_imem_req,
    output logic [63:0]      o_imem_addr,
    input  logic             i_imem_rvalid,
    input  logic [31:0]      i_imem_rdata,
    output logic [63:0]      o_pc_f,
    output logic [31:0]      o_instr_f,
    output logic             o_valid_f,
    output logic [CNT_W-1:0] o_bubble_cnt
);

    // IDLE: first cycle after reset, issues the first request.
    // WAIT: a request is outstanding and its data will be used.
    // DROP: a request is outstanding but was killed by a redirect.
    // HOLD: returned data parked in r_buf while fetch is stalled.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [63:0]       r_pc;
    logic [63:0]       w_pc_nxt;
    logic [31:0]       r_buf;
    logic              w_buf_load;
    logic [CNT_W-1:0]  r_bubble;

    logic [63:0]       w_target;
    logic [63:0]       w_pc_inc;
    logic              w_req;
    logic              w_valid;
    logic              w_use_buf;

    // Instructions are word aligned, so the low target bits are dropped.
    assign w_target = {i_pctarget_e[63:2], 2'b00};
    // Modulo-2^64 increment; the top word wraps to address zero.
    assign w_pc_inc = r_pc + 64'd4;

    // ------------------------------------------------------------------
    // State register (with the PC, hold buffer and bubble counter)
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_buf    <= NOP_INSTR;
            r_bubble <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            if (w_buf_load) begin
                r_buf <= i_imem_rdata;
            end
            // A stalled cycle is not a bubble: the decode side is frozen.
            if (!w_valid && !i_stall_f && (r_bubble != CNT_MAX)) begin
                r_bubble <= r_bubble + CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Every request address equals the PC loaded here,
    // so r_pc always names the outstanding (or held) fetch.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_buf_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pc_nxt    = i_pcsrc_e ? w_target : r_pc;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    if (i_pcsrc_e) begin
                        // Returned word belongs to the killed path.
                        w_pc_nxt = w_target;
                    end else if (!i_stall_f) begin
                        w_pc_nxt = w_pc_inc;
                    end else begin
                        w_buf_load  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (i_pcsrc_e) begin
                    // Cannot cancel the in-flight read; remember to drop it.
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (i_imem_rvalid) begin
                    w_pc_nxt    = i_pcsrc_e ? w_target : r_pc;
                    w_state_nxt = S_WAIT;
                end else if (i_pcsrc_e) begin
                    w_pc_nxt = w_target;
                end
            end
            S_HOLD: begin
                if (i_pcsrc_e) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_WAIT;
                end else if (!i_stall_f) begin
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = S_WAIT;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic. A redirect always suppresses the valid instruction.
    // ------------------------------------------------------------------
    always_comb begin
        w_req     = 1'b0;
        w_valid   = 1'b0;
        w_use_buf = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req = 1'b1;
            end
            S_WAIT: begin
                if (i_imem_rvalid) begin
                    if (i_pcsrc_e) begin
                        w_req = 1'b1;
                    end else if (!i_stall_f) begin
                        w_req   = 1'b1;
                        w_valid = 1'b1;
                    end
                end
            end
            S_DROP: begin
                w_req = i_imem_rvalid;
            end
            S_HOLD: begin
                if (i_pcsrc_e) begin
                    w_req = 1'b1;
                end else begin
                    w_valid   = 1'b1;
                    w_use_buf = 1'b1;
                    w_req     = !i_stall_f;
                end
            end
            default: begin
                w_req = 1'b0;
            end
        endcase
    end

    // The IDLE request must not escape while reset is still held.
    assign o_imem_req   = w_req & ~i_rst;
    assign o_imem_addr  = w_pc_nxt;
    assign o_valid_f    = w_valid;
    assign o_pc_f       = r_pc;
    assign o_instr_f    = !w_valid  ? NOP_INSTR :
                          w_use_buf ? r_buf     : i_imem_rdata;
    assign o_bubble_cnt = r_bubble;

    // Read data may only return while a request is outstanding.
    a_rvalid_outstanding: assert property (
        @(posedge i_clk) disable iff (i_rst)
        i_imem_rvalid |-> ((r_state == S_WAIT) || (r_state == S_DROP))
    );

endmodule
